// File: rtl/vhm_fetch_sequencer.sv
// Fetch/issue sequencer for the VHM RV64IM core: owns the PC, fetches one word at a
// time, hands it to execute, then selects pc+4 or the execute-supplied next PC.
module vhm_fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [15:0] TIMEOUT  = 16'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        exec_done,
   input  logic        exec_redirect,
   input  logic [63:0] exec_dnpc,
   input  logic        exec_error,
   output logic        busy,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [63:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_EXEC  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   localparam logic [1:0] FAULT_NONE    = 2'd0;
   localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
   localparam logic [1:0] FAULT_MISALIGN = 2'd2;
   localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [63:0] pc_r;
   logic [63:0] pc_nxt_s;
   logic [1:0]  fault_r;
   logic [1:0]  fault_nxt_s;
   logic [63:0] retired_r;
   logic [63:0] retired_nxt_s;
   logic [31:0] inst_r;
   logic [31:0] inst_nxt_s;
   logic [63:0] inst_pc_r;
   logic [63:0] inst_pc_nxt_s;
   logic [15:0] wait_cnt_r;
   logic [15:0] wait_cnt_nxt_s;
   logic        req_valid_r;
   logic        inst_valid_r;
   logic        busy_r;
   logic        halted_r;

   logic [63:0] seq_pc_s;
   logic [16:0] wait_inc_s;

   assign seq_pc_s   = exec_redirect ? exec_dnpc : (pc_r + 64'd4);
   // One bit wider than the counter so the timeout compare cannot wrap.
   assign wait_inc_s = {1'b0, wait_cnt_r} + 17'd1;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath next-value selection.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      fault_nxt_s    = fault_r;
      retired_nxt_s  = retired_r;
      inst_nxt_s     = inst_r;
      inst_pc_nxt_s  = inst_pc_r;
      wait_cnt_nxt_s = wait_cnt_r;
      case (state_r)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_nxt_s   = S_REQ;
               pc_nxt_s      = RESET_PC;
               retired_nxt_s = 64'd0;
               fault_nxt_s   = FAULT_NONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               state_nxt_s    = S_WAIT;
               wait_cnt_nxt_s = 16'd0;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            if (mem_rsp_valid) begin
               state_nxt_s   = S_ISSUE;
               inst_nxt_s    = mem_rsp_data;
               inst_pc_nxt_s = pc_r;
            end else if (wait_inc_s >= {1'b0, TIMEOUT}) begin
               state_nxt_s = S_HALT;
               fault_nxt_s = FAULT_TIMEOUT;
            end else begin
               wait_cnt_nxt_s = wait_inc_s[15:0];
            end
         end
         S_ISSUE: begin
            if (inst_ready) begin
               state_nxt_s = S_EXEC;
            end else begin
               state_nxt_s = S_ISSUE;
            end
         end
         S_EXEC: begin
            if (!exec_done) begin
               state_nxt_s = S_EXEC;
            end else if (exec_error) begin
               // Faulting instruction does not retire and leaves the PC on itself.
               state_nxt_s = S_HALT;
               fault_nxt_s = FAULT_ILLEGAL;
            end else begin
               retired_nxt_s = retired_r + 64'd1;
               pc_nxt_s      = seq_pc_s;
               if (seq_pc_s[1:0] != 2'b00) begin
                  state_nxt_s = S_HALT;
                  fault_nxt_s = FAULT_MISALIGN;
               end else if (stop) begin
                  state_nxt_s = S_HALT;
                  fault_nxt_s = FAULT_NONE;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Datapath registers and registered status/valid outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r         <= RESET_PC;
         fault_r      <= FAULT_NONE;
         retired_r    <= 64'd0;
         inst_r       <= 32'd0;
         inst_pc_r    <= 64'd0;
         wait_cnt_r   <= 16'd0;
         req_valid_r  <= 1'b0;
         inst_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         halted_r     <= 1'b0;
      end else begin
         pc_r         <= pc_nxt_s;
         fault_r      <= fault_nxt_s;
         retired_r    <= retired_nxt_s;
         inst_r       <= inst_nxt_s;
         inst_pc_r    <= inst_pc_nxt_s;
         wait_cnt_r   <= wait_cnt_nxt_s;
         req_valid_r  <= (state_nxt_s == S_REQ);
         inst_valid_r <= (state_nxt_s == S_ISSUE);
         busy_r       <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_HALT);
         halted_r     <= (state_nxt_s == S_HALT);
      end
   end

   assign mem_req_valid = req_valid_r;
   assign mem_req_addr  = pc_r;
   assign inst_valid    = inst_valid_r;
   assign inst          = inst_r;
   assign inst_pc       = inst_pc_r;
   assign busy          = busy_r;
   assign halted        = halted_r;
   assign fault         = fault_r;
   assign retired       = retired_r;

endmodule

// File: tb/tb_vhm_fetch_sequencer.sv
// Directed self-checking bench for vhm_fetch_sequencer: straight-line run, redirect,
// PC wrap, illegal instruction, backpressure, fetch timeout and reset mid-fetch.
module tb_vhm_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        exec_done;
   logic        exec_redirect;
   logic [63:0] exec_dnpc;
   logic        exec_error;
   logic        busy;
   logic        halted;
   logic [1:0]  fault;
   logic [63:0] retired;

   int n_assert = 0;
   int n_fail   = 0;

   vhm_fetch_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready),
      .mem_req_addr (mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data (mem_rsp_data),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .exec_done    (exec_done),
      .exec_redirect(exec_redirect),
      .exec_dnpc    (exec_dnpc),
      .exec_error   (exec_error),
      .busy         (busy),
      .halted       (halted),
      .fault        (fault),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: observed no end of test, expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expects to be called in the REQ cycle; leaves the DUT in ISSUE.
   task automatic fetch(input logic [63:0] addr, input logic [31:0] word,
                        input int rdy_dly, input int rsp_dly, input bit early);
      chk1("req_valid", mem_req_valid, 1'b1);
      chk("req_addr", mem_req_addr, addr);
      chk1("busy_req", busy, 1'b1);
      for (int i = 0; i < rdy_dly; i++) begin
         mem_req_ready = 1'b0;
         @(negedge clk);
         chk1("req_hold_valid", mem_req_valid, 1'b1);
         chk("req_hold_addr", mem_req_addr, addr);
      end
      mem_req_ready = 1'b1;
      if (early) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 32'hBAD0_0BAD;
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      chk1("wait_req_low", mem_req_valid, 1'b0);
      chk1("wait_inst_low", inst_valid, 1'b0);
      for (int i = 0; i < rsp_dly; i++) begin
         @(negedge clk);
         chk1("wait_hold_inst_low", inst_valid, 1'b0);
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0000_0000;
   endtask

   // Expects ISSUE; leaves the DUT in EXEC.
   task automatic issue(input logic [31:0] word, input logic [63:0] pc, input int dly);
      for (int i = 0; i < dly; i++) begin
         inst_ready = 1'b0;
         chk1("issue_hold_valid", inst_valid, 1'b1);
         chk("issue_hold_inst", 64'(inst), 64'(word));
         chk("issue_hold_pc", inst_pc, pc);
         @(negedge clk);
      end
      chk1("issue_valid", inst_valid, 1'b1);
      chk("issue_inst", 64'(inst), 64'(word));
      chk("issue_pc", inst_pc, pc);
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      chk1("exec_inst_low", inst_valid, 1'b0);
   endtask

   // Expects EXEC; noise on stop/redirect while exec_done is low must be ignored.
   task automatic exec_step(input bit redir, input logic [63:0] dnpc, input bit err,
                            input bit stp, input int done_dly);
      for (int i = 0; i < done_dly; i++) begin
         exec_done     = 1'b0;
         stop          = 1'b1;
         exec_redirect = 1'b1;
         exec_dnpc     = 64'h3;
         @(negedge clk);
      end
      exec_done     = 1'b1;
      exec_redirect = redir;
      exec_dnpc     = dnpc;
      exec_error    = err;
      stop          = stp;
      @(negedge clk);
      exec_done     = 1'b0;
      exec_redirect = 1'b0;
      exec_dnpc     = 64'h0;
      exec_error    = 1'b0;
      stop          = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b1;
      stop          = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      inst_ready    = 1'b0;
      exec_done     = 1'b0;
      exec_redirect = 1'b0;
      exec_dnpc     = 64'h0;
      exec_error    = 1'b0;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);

      // Reset state; start held during reset had no effect.
      chk1("rst_req_valid", mem_req_valid, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_halted", halted, 1'b0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_retired", retired, 64'd0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
      chk("rst_addr", mem_req_addr, 64'h8000_0000);

      // Straight-line run, stop on the third completion.
      pulse_start();
      fetch(64'h8000_0000, 32'h0000_0013, 0, 0, 1'b1);
      issue(32'h0000_0013, 64'h8000_0000, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b0, 0);
      stop = 1'b1;
      fetch(64'h8000_0004, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'h8000_0004, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b0, 2);
      chk("line_retired2", retired, 64'd2);
      fetch(64'h8000_0008, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'h8000_0008, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b1, 0);
      chk1("line_halted", halted, 1'b1);
      chk1("line_busy", busy, 1'b0);
      chk("line_fault", 64'(fault), 64'd0);
      chk("line_retired", retired, 64'd3);
      chk("line_pc", mem_req_addr, 64'h8000_000C);

      // Redirect, then redirect to a misaligned target.
      pulse_start();
      chk("redir_retired_clr", retired, 64'd0);
      fetch(64'h8000_0000, 32'h0000_006F, 0, 0, 1'b0);
      issue(32'h0000_006F, 64'h8000_0000, 0);
      exec_step(1'b1, 64'h8000_0100, 1'b0, 1'b0, 0);
      fetch(64'h8000_0100, 32'h0000_0067, 0, 0, 1'b0);
      issue(32'h0000_0067, 64'h8000_0100, 0);
      exec_step(1'b1, 64'h8000_0102, 1'b0, 1'b0, 0);
      chk1("mis_halted", halted, 1'b1);
      chk("mis_fault", 64'(fault), 64'd2);
      chk("mis_retired", retired, 64'd2);
      chk("mis_pc", mem_req_addr, 64'h8000_0102);

      // PC+4 wraps modulo 2^64.
      pulse_start();
      chk("wrap_fault_clr", 64'(fault), 64'd0);
      fetch(64'h8000_0000, 32'h0000_006F, 0, 0, 1'b0);
      issue(32'h0000_006F, 64'h8000_0000, 0);
      exec_step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 0);
      fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b0, 0);
      fetch(64'h0, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'h0, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b1, 0);
      chk1("wrap_halted", halted, 1'b1);
      chk("wrap_retired", retired, 64'd3);
      chk("wrap_pc", mem_req_addr, 64'h4);

      // Illegal instruction on the second fetch; redirect must not move the PC.
      pulse_start();
      fetch(64'h8000_0000, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'h8000_0000, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b0, 0);
      fetch(64'h8000_0004, 32'hFFFF_FFFF, 0, 0, 1'b0);
      issue(32'hFFFF_FFFF, 64'h8000_0004, 0);
      exec_step(1'b1, 64'h8000_0200, 1'b1, 1'b0, 0);
      chk1("ill_halted", halted, 1'b1);
      chk1("ill_busy", busy, 1'b0);
      chk("ill_fault", 64'(fault), 64'd1);
      chk("ill_retired", retired, 64'd1);
      chk("ill_pc", mem_req_addr, 64'h8000_0004);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1234_5678;
      exec_done     = 1'b1;
      inst_ready    = 1'b1;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      exec_done     = 1'b0;
      inst_ready    = 1'b0;
      mem_req_ready = 1'b0;
      chk1("halt_ignore_halted", halted, 1'b1);
      chk("halt_ignore_fault", 64'(fault), 64'd1);
      chk("halt_ignore_retired", retired, 64'd1);
      chk("halt_ignore_inst", 64'(inst), 64'hFFFF_FFFF);
      chk1("halt_ignore_req", mem_req_valid, 1'b0);

      // Backpressure on both handshakes, then a fetch timeout.
      pulse_start();
      fetch(64'h8000_0000, 32'h00A0_0093, 5, 2, 1'b0);
      issue(32'h00A0_0093, 64'h8000_0000, 3);
      exec_step(1'b0, 64'h0, 1'b0, 1'b0, 0);
      chk1("to_req_valid", mem_req_valid, 1'b1);
      chk("to_req_addr", mem_req_addr, 64'h8000_0004);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      repeat (254) @(negedge clk);
      chk1("to_busy_254", busy, 1'b1);
      chk1("to_halted_254", halted, 1'b0);
      @(negedge clk);
      chk1("to_halted", halted, 1'b1);
      chk1("to_busy", busy, 1'b0);
      chk("to_fault", 64'(fault), 64'd3);
      chk("to_retired", retired, 64'd1);

      // Reset while waiting for a response; the late response is dropped.
      pulse_start();
      chk1("rw_req_valid", mem_req_valid, 1'b1);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk1("rw_busy_wait", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("rw_busy", busy, 1'b0);
      chk1("rw_req_valid0", mem_req_valid, 1'b0);
      chk1("rw_inst_valid", inst_valid, 1'b0);
      chk1("rw_halted", halted, 1'b0);
      chk("rw_inst", 64'(inst), 64'd0);
      chk("rw_inst_pc", inst_pc, 64'd0);
      chk("rw_addr", mem_req_addr, 64'h8000_0000);
      @(negedge clk);
      rst           = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
      chk1("rw_late_busy", busy, 1'b0);
      chk1("rw_late_inst_valid", inst_valid, 1'b0);
      chk("rw_late_inst", 64'(inst), 64'd0);
      pulse_start();
      fetch(64'h8000_0000, 32'h0000_0013, 0, 0, 1'b0);
      issue(32'h0000_0013, 64'h8000_0000, 0);
      exec_step(1'b0, 64'h0, 1'b0, 1'b1, 0);
      chk1("rw_end_halted", halted, 1'b1);
      chk("rw_end_retired", retired, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vhm_fetch_sequencer.md
# vhm_fetch_sequencer

Instruction fetch/issue sequencer for the RV64IM virtual hardware machine (VHM). It owns the program counter, fetches one 32-bit instruction at a time over a request/response memory port, and issues it to the single-cycle execute datapath with a valid/ready handshake. It then waits for execute completion and selects the next PC: the static next PC (pc+4) or the execute-supplied dynamic next PC. It halts on illegal-instruction status, misaligned target, memory timeout or external stop.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset and on every start.
- TIMEOUT, 255, maximum cycles waiting for a memory response; width 16 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution from RESET_PC.
- stop  in  1  level; requests a halt at the next instruction boundary.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  64  fetch address (current PC).
- mem_rsp_valid  in  1  fetch data valid.
- mem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction presented to execute.
- inst_ready  in  1  execute accepts the instruction.
- inst  out  32  instruction word.
- inst_pc  out  64  PC of the issued instruction.
- exec_done  in  1  execute finished the issued instruction.
- exec_redirect  in  1  qualified by exec_done; take exec_dnpc instead of pc+4.
- exec_dnpc  in  64  dynamic next PC (JAL/JALR/branch target).
- exec_error  in  1  qualified by exec_done; execute status high (illegal instruction).
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- fault  out  2  0 none/stop, 1 illegal instruction, 2 misaligned target, 3 fetch timeout.
- retired  out  64  count of instructions completed without error.

## Operation
- States: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
- IDLE: start → PC=RESET_PC, retired=0, fault=0, go to REQ. Otherwise remain.
- REQ: mem_req_valid=1, mem_req_addr=PC. On mem_req_ready → WAIT with timeout counter=0.
- WAIT: on mem_rsp_valid → latch data into inst, set inst_pc=PC, go to ISSUE. Otherwise increment the counter. When the counter reaches TIMEOUT without a response → HALT with fault=3.
- ISSUE: inst_valid=1, and inst/inst_pc are held stable. On inst_ready → EXEC.
- EXEC: wait for exec_done. Then, in priority order:
  - exec_error → HALT, fault=1, PC unchanged, retired not incremented.
  - Otherwise compute next = exec_redirect ? exec_dnpc : PC+4, and increment retired.
  - next[1:0]≠0 → HALT, fault=2, PC=next.
  - stop → HALT, fault=0, PC=next.
  - Else PC=next → REQ.
- stop is sampled only in EXEC on exec_done; an in-flight fetch is never abandoned.
- HALT: start → same as start in IDLE (restart). All other inputs are ignored.
- Inputs are ignored outside their owning state: mem_rsp_valid outside WAIT, exec_done outside EXEC, start outside IDLE/HALT.
- PC+4 and retired wrap modulo 2^64. The retired counter has no saturation.

## Timing
- Reset (async): state=IDLE; mem_req_valid=0, inst_valid=0, busy=0, halted=0, fault=0, retired=0, inst=0, inst_pc=0, mem_req_addr=RESET_PC.
- Outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Minimum instruction period is 4 cycles, with zero-wait memory and execute: REQ, WAIT, ISSUE, EXEC.
  - With mem_req_ready=1 in REQ and mem_rsp_valid=1 in the first WAIT cycle, inst_valid rises 2 cycles after REQ entry.
- mem_rsp_valid in the same cycle as the req handshake is ignored; the response is accepted from the first WAIT cycle.
- Valid signals stay high until handshake. Data does not change while valid is high and ready is low.
- Reset asserted mid-operation returns to IDLE immediately and drops every valid. A pending response arriving after reset is ignored.
- start asserted while rst is high is ignored.

## Test plan
- Straight-line run:
  - Stimulus: start; zero-wait memory returns 0x00000013 (NOP) for every address; exec_done each EXEC, no redirect; stop asserted on the 3rd exec_done.
  - Required: fetch addresses 0x80000000, 0x80000004, 0x80000008; HALT; fault=0; retired=3; PC=0x8000000C.
- Redirect:
  - Stimulus: redirect with exec_dnpc=0x80000100.
  - Required: next mem_req_addr=0x80000100.
  - Stimulus: redirect with exec_dnpc=0x80000102.
  - Required: HALT, fault=2, retired incremented.
- Illegal instruction:
  - Stimulus: exec_error=1 on the 2nd instruction.
  - Required: HALT, fault=1, retired=1, halted=1, busy=0.
- Backpressure and timeout:
  - Stimulus: mem_req_ready low for 5 cycles, then inst_ready low for 3 cycles.
  - Required: addr/inst held stable throughout.
  - Stimulus: withhold mem_rsp_valid for 255 cycles.
  - Required: HALT, fault=3.
- Reset mid-WAIT:
  - Stimulus: assert rst during WAIT, then deliver mem_rsp_valid.
  - Required: immediate IDLE, all outputs at reset values, late response ignored; subsequent start refetches 0x80000000.
